// File: rtl/bloom_hash_gen.sv
// rtl/bloom_hash_gen.sv - nine-lane rolling byte hash with modulo reduction for the bloom filter
// Keys stream in a byte at a time; each lane keeps its own rotate/xor hash, reduced once per key.
module bloom_hash_gen #(
  parameter int         BLOOM_DEPTH = 115,
  parameter int         MAX_LEN     = 64,
  parameter logic [7:0] SEED_BASE   = 8'h5A
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] hash0_o,
  output logic [7:0] hash1_o,
  output logic [7:0] hash2_o,
  output logic [7:0] hash3_o,
  output logic [7:0] hash4_o,
  output logic [7:0] hash5_o,
  output logic [7:0] hash6_o,
  output logic [7:0] hash7_o,
  output logic [7:0] hash8_o,
  output logic       hash_valid_o,
  input  logic       hash_ready_i,
  output logic       trunc_o
);

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_REDUCE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  localparam int RED_STEPS = (256 + BLOOM_DEPTH - 1) / BLOOM_DEPTH;

  logic [1:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       trunc_q, trunc_d;
  logic [7:0] h_q   [9];
  logic [7:0] h_d   [9];
  logic [7:0] idx_q [9];
  logic [7:0] idx_d [9];

  function automatic logic [7:0] lane_seed(input int k);
    return SEED_BASE ^ 8'(k * 29);
  endfunction

  // Repeated conditional subtraction; enough steps to bring any byte below BLOOM_DEPTH.
  function automatic logic [7:0] reduce_idx(input logic [7:0] h);
    int v;
    v = int'(h);
    for (int i = 0; i < RED_STEPS; i++) begin
      if (v >= BLOOM_DEPTH) v = v - BLOOM_DEPTH;
    end
    return 8'(v);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    for (int k = 0; k < 9; k++) begin
      h_d[k]   = h_q[k];
      idx_d[k] = idx_q[k];
    end
    case (state_q)
      ST_ACCUM: begin
        if (valid_i) begin
          for (int k = 0; k < 9; k++) begin
            h_d[k] = {h_q[k][6:0], h_q[k][7]} ^ (data_i + 8'(k));
          end
          cnt_d = cnt_q + 7'd1;
          if (last_i || (cnt_q == 7'(MAX_LEN - 1))) begin
            state_d = ST_REDUCE;
            trunc_d = ~last_i;
          end
        end
      end
      ST_REDUCE: begin
        for (int k = 0; k < 9; k++) begin
          idx_d[k] = reduce_idx(h_q[k]);
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (hash_ready_i) begin
          for (int k = 0; k < 9; k++) begin
            h_d[k] = lane_seed(k);
          end
          cnt_d   = 7'd0;
          trunc_d = 1'b0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ACCUM;
      cnt_q   <= 7'd0;
      trunc_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        h_q[k]   <= lane_seed(k);
        idx_q[k] <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      for (int k = 0; k < 9; k++) begin
        h_q[k]   <= h_d[k];
        idx_q[k] <= idx_d[k];
      end
    end
  end

  assign ready_o      = (state_q == ST_ACCUM);
  assign hash_valid_o = (state_q == ST_OUT);
  assign trunc_o      = trunc_q;
  assign hash0_o      = idx_q[0];
  assign hash1_o      = idx_q[1];
  assign hash2_o      = idx_q[2];
  assign hash3_o      = idx_q[3];
  assign hash4_o      = idx_q[4];
  assign hash5_o      = idx_q[5];
  assign hash6_o      = idx_q[6];
  assign hash7_o      = idx_q[7];
  assign hash8_o      = idx_q[8];

endmodule
